uart_lite_sequencer: RTL

UART_LITE_SEQUENCER -- requirements
Module: uart_lite_sequencer

---
 rtl/uart_lite_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_lite_sequencer.sv
// rtl/uart_lite_sequencer.sv - AXI-Lite master that sequences a UART's TX/RX/STAT/CTRL registers
module uart_lite_sequencer #(
    parameter int unsigned POLL_CYCLES = 255,
    parameter logic [12:0] BASE_ADDR   = 13'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic        uart_irq_i,
    output logic [12:0] m_axi_uart_awaddr,
    output logic        m_axi_uart_awvalid,
    input  logic        m_axi_uart_awready,
    output logic [31:0] m_axi_uart_wdata,
    output logic [3:0]  m_axi_uart_wstrb,
    output logic        m_axi_uart_wvalid,
    input  logic        m_axi_uart_wready,
    input  logic [1:0]  m_axi_uart_bresp,
    input  logic        m_axi_uart_bvalid,
    output logic        m_axi_uart_bready,
    output logic [12:0] m_axi_uart_araddr,
    output logic        m_axi_uart_arvalid,
    input  logic        m_axi_uart_arready,
    input  logic [31:0] m_axi_uart_rdata,
    input  logic [1:0]  m_axi_uart_rresp,
    input  logic        m_axi_uart_rvalid,
    output logic        m_axi_uart_rready,
    output logic        err_o
);

    localparam logic [12:0] ADDR_RX   = BASE_ADDR;
    localparam logic [12:0] ADDR_TX   = BASE_ADDR + 13'h4;
    localparam logic [12:0] ADDR_STAT = BASE_ADDR + 13'h8;
    localparam logic [12:0] ADDR_CTRL = BASE_ADDR + 13'hC;
    localparam logic [15:0] POLL_LAST = 16'(POLL_CYCLES - 1);
    localparam logic [31:0] CTRL_INIT = 32'h13;

    typedef enum logic [3:0] {
        INIT_W, INIT_B, IDLE, STAT_AR, STAT_R, TX_W, TX_B, RX_AR, RX_R
    } state_t;

    state_t      state, state_nx;
    logic        aw_done, w_done;
    logic [7:0]  tx_byte;
    logic [15:0] poll_cnt;
    logic        is_w, aw_hs, w_hs, b_hs, r_hs;
    logic        unused_rdata;

    assign unused_rdata = ^m_axi_uart_rdata[31:8];

    assign is_w  = (state == INIT_W) || (state == TX_W);
    assign aw_hs = m_axi_uart_awvalid && m_axi_uart_awready;
    assign w_hs  = m_axi_uart_wvalid && m_axi_uart_wready;
    assign b_hs  = m_axi_uart_bvalid && m_axi_uart_bready;
    assign r_hs  = m_axi_uart_rvalid && m_axi_uart_rready;

    // Write channel is combinational from state so the CTRL write is offered
    // immediately after reset; rst_i masks it so reset forces everything low.
    assign m_axi_uart_awvalid = is_w && !aw_done && !rst_i;
    assign m_axi_uart_wvalid  = is_w && !w_done && !rst_i;
    assign m_axi_uart_wstrb   = 4'hF;
    assign m_axi_uart_bready  = (state == INIT_B) || (state == TX_B);
    assign m_axi_uart_arvalid = (state == STAT_AR) || (state == RX_AR);
    assign m_axi_uart_rready  = (state == STAT_R) || (state == RX_R);

    always_comb begin
        m_axi_uart_awaddr = '0;
        m_axi_uart_wdata  = '0;
        m_axi_uart_araddr = '0;
        if (!rst_i) begin
            case (state)
                INIT_W: begin
                    m_axi_uart_awaddr = ADDR_CTRL;
                    m_axi_uart_wdata  = CTRL_INIT;
                end
                TX_W: begin
                    m_axi_uart_awaddr = ADDR_TX;
                    m_axi_uart_wdata  = {24'h0, tx_byte};
                end
                STAT_AR: m_axi_uart_araddr = ADDR_STAT;
                RX_AR:   m_axi_uart_araddr = ADDR_RX;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        tx_ready_o = 1'b0;
        case (state)
            INIT_W, TX_W: begin
                if ((aw_done || aw_hs) && (w_done || w_hs))
                    state_nx = (state == INIT_W) ? INIT_B : TX_B;
            end
            INIT_B, TX_B: begin
                if (m_axi_uart_bvalid) state_nx = IDLE;
            end
            IDLE: begin
                if (tx_valid_i || uart_irq_i || (poll_cnt == POLL_LAST))
                    state_nx = STAT_AR;
            end
            STAT_AR: if (m_axi_uart_arready) state_nx = STAT_R;
            STAT_R: begin
                if (m_axi_uart_rvalid) begin
                    // A pending RX byte wins over TX so the receive FIFO drains first.
                    if (m_axi_uart_rdata[0] && !rx_valid_o) begin
                        state_nx = RX_AR;
                    end else if (tx_valid_i && !m_axi_uart_rdata[3]) begin
                        state_nx   = TX_W;
                        tx_ready_o = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            RX_AR: if (m_axi_uart_arready) state_nx = RX_R;
            RX_R:  if (m_axi_uart_rvalid) state_nx = IDLE;
            default: state_nx = INIT_W;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= INIT_W;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            tx_byte    <= '0;
            poll_cnt   <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nx;
            if (is_w && (state_nx == state)) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (tx_ready_o) tx_byte <= tx_data_i;
            if ((state == IDLE) && (state_nx == IDLE))
                poll_cnt <= poll_cnt + 16'd1;
            else
                poll_cnt <= '0;
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            if ((state == RX_R) && r_hs && (m_axi_uart_rresp == 2'b00)) begin
                rx_data_o  <= m_axi_uart_rdata[7:0];
                rx_valid_o <= 1'b1;
            end
            if ((b_hs && (m_axi_uart_bresp != 2'b00)) || (r_hs && (m_axi_uart_rresp != 2'b00)))
                err_o <= 1'b1;
        end
    end

endmodule
